axis_ad7763_emu: RTL and testbench
==================================

# axis_ad7763_emu

AD7763 ADC serial-interface emulator: the transmitter counterpart of the AD7763 receiver core. Takes 24-bit samples on an AXI-Stream slave and drives the ADC serial output pins: SCO, FSO negated, SDO, plus a tri-state enable. Captures register-write frames arriving on FSI/SDI and presents them as address/data words. Used in loopback benches and hardware self-test to stand in for the physical converter.

## Interface
- CLK_DIV, 2: aclk cycles per SCO half-period (≥1); SCO = aclk/(2·CLK_DIV)
- FRAME_GAP, 0: idle SCO periods inserted between frames (FSO_n high, SDO 0)
- aclk  in  1  single clock; all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  run; frames start only while high
- status  in  7  ST6..ST0 bits sent after each sample
- s_axis_tdata  in  24  sample, two's complement
- s_axis_tvalid  in  1  sample valid
- s_axis_tready  out  1  hold register empty
- adc_sco  out  1  serial clock out
- adc_fson  out  1  frame sync out, active low
- adc_sdo  out  1  serial data out
- adc_sdo_t  out  1  1 = SDO tri-stated (tri-state bit / idle)
- adc_fsin  in  1  frame sync in, active low
- adc_sdi  in  1  serial data in
- cfg_addr  out  16  last received register address
- cfg_data  out  16  last received register data
- cfg_valid  out  1  one-cycle pulse when cfg_addr/cfg_data update
- underrun  out  1  one-cycle pulse: frame started with hold register empty

## Operation
- SCO generator: divider counter 0..CLK_DIV-1; adc_sco toggles on wrap. fall_en = cycle adc_sco goes 1→0, rise_en = 0→1.
- All TX outputs update only in fall_en cycles; receiver samples on SCO rising edge.
- Frame = 33 SCO periods, index p: p=0 FSO_n=0, SDO=0, sdo_t=0; p=1..24 D23..D0 (MSB first); p=25..31 ST6..ST0; p=32 SDO=0, sdo_t=1. Then FRAME_GAP idle periods.
- FSM: IDLE → (fall_en & enable) → FRAME → (p=32 done) → GAP (skipped if FRAME_GAP=0) → FRAME if enable else IDLE.
- Sample source: 1-entry hold register. s_axis_tready = hold empty; transfer on tvalid&tready. At p=0 load shift register from hold and clear it; status latched at p=0.
- Hold empty at p=0: resend previous sample (0 after reset), pulse underrun.
- enable deasserted mid-frame: current frame completes; then IDLE.
- RX: in rise_en cycles, adc_fsin=0 arms capture; the following 32 rise_en samples of adc_sdi shift in MSB first (16-bit address then 16-bit data). After bit 32: cfg_addr/cfg_data update, cfg_valid pulses one aclk. FSI low again before completion restarts capture (partial word discarded). RX runs independently of enable.

## Timing
- Reset values: adc_sco 0, adc_fson 1, adc_sdo 0, adc_sdo_t 1, s_axis_tready 0 (1 from first cycle after release), cfg_addr/cfg_data 0, cfg_valid 0, underrun 0; FSM IDLE, hold empty.
- Reset mid-frame: outputs return to reset values immediately (asynchronous); no partial frame resumes.
- Frame period = (33+FRAME_GAP)·2·CLK_DIV aclk; CLK_DIV=2, gap 0 → 132 cycles.
- Simultaneous tvalid and p=0 load with hold empty: sample is not used in this frame (underrun); it fills hold for next frame.
- Simultaneous load and new transfer with hold full: load wins, hold refills same cycle (tready registered, so accepted next cycle).
- cfg_valid asserts 1 aclk after the 32nd rise_en.

## Structure
- Package ad7763_pkg: FRAME_BITS=33, DATA_BITS=24, STATUS_BITS=7, CFG_BITS=32, FSM state enum; shared with the receiver core.
- Sub-module ad7763_sco_gen: divider producing adc_sco, rise_en, fall_en.

## Test plan
- Reset release, enable=1, push 24'hA5A5A5, status 7'h55 → FSO_n low one SCO period, then SDO bits A5A5A5, 1010101, sdo_t high at p=32; frame 132 aclk (CLK_DIV=2).
- Back-to-back samples 1,2,3 with tvalid held → three consecutive frames, no gap, no underrun.
- No sample pushed after first frame → second frame repeats 24'hA5A5A5, underrun pulses exactly once.
- FRAME_GAP=3 → 3 idle SCO periods (FSO_n high, sdo_t 1) between frames.
- FSI low then 32 SDI bits 32'h0001_1234 → cfg_addr 16'h0001, cfg_data 16'h1234, cfg_valid one pulse; FSI re-low after 10 bits → no pulse.
- Deassert aresetn at p=12 → outputs at reset values immediately; after release first frame restarts at p=0 with next pushed sample.

Source files
------------

// File: rtl/ad7763_pkg.sv
// rtl/ad7763_pkg.sv - AD7763 serial frame constants and TX state type, shared with the receiver core
package ad7763_pkg;

  localparam int FRAME_BITS  = 33;
  localparam int DATA_BITS   = 24;
  localparam int STATUS_BITS = 7;
  localparam int CFG_BITS    = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_GAP
  } tx_state_e;

endpackage

// File: rtl/ad7763_sco_gen.sv
// rtl/ad7763_sco_gen.sv - SCO divider; rise_en/fall_en flag the cycle whose edge moves adc_sco
module ad7763_sco_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic aclk,
  input  logic aresetn,
  output logic sco,
  output logic rise_en,
  output logic fall_en
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [15:0] div_q, div_d;
  logic        sco_q, sco_d;
  logic        wrap;

  always_comb begin
    wrap  = (div_q == DIV_LAST);
    div_d = wrap ? '0 : div_q + 16'd1;
    sco_d = wrap ? ~sco_q : sco_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_q <= '0;
      sco_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sco_q <= sco_d;
    end
  end

  assign sco     = sco_q;
  assign rise_en = wrap & ~sco_q;
  assign fall_en = wrap & sco_q;

endmodule

// File: rtl/axis_ad7763_emu.sv
// rtl/axis_ad7763_emu.sv - AD7763 serial-output emulator fed from AXI-Stream, with FSI/SDI register capture
module axis_ad7763_emu
  import ad7763_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int FRAME_GAP = 0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [STATUS_BITS-1:0] status,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic                   adc_sco,
  output logic                   adc_fson,
  output logic                   adc_sdo,
  output logic                   adc_sdo_t,
  input  logic                   adc_fsin,
  input  logic                   adc_sdi,
  output logic [15:0]            cfg_addr,
  output logic [15:0]            cfg_data,
  output logic                   cfg_valid,
  output logic                   underrun
);

  localparam int          SHIFT_BITS = DATA_BITS + STATUS_BITS;
  localparam logic [5:0]  P_LAST     = 6'(FRAME_BITS - 1);
  localparam logic [5:0]  RX_LAST    = 6'(CFG_BITS - 1);
  localparam logic [15:0] GAP_LAST   = 16'(FRAME_GAP - 1);

  logic rise_en, fall_en;

  ad7763_sco_gen #(.CLK_DIV(CLK_DIV)) u_sco_gen (
    .aclk    (aclk),
    .aresetn (aresetn),
    .sco     (adc_sco),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  tx_state_e             state_q, state_d;
  logic [5:0]            p_q, p_d, p_next;
  logic [15:0]           gap_q, gap_d;
  logic [SHIFT_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0]  last_q, last_d, hold_q, hold_d;
  logic                  hold_full_q, hold_full_d, tready_q, tready_d;
  logic                  fson_q, fson_d, sdo_q, sdo_d, sdo_t_q, sdo_t_d;
  logic                  underrun_q, underrun_d;
  logic                  start, go_idle, xfer;

  logic                  rx_active_q, rx_active_d;
  logic [5:0]            rx_cnt_q, rx_cnt_d;
  logic [CFG_BITS-2:0]   rx_sr_q, rx_sr_d;
  logic [CFG_BITS-1:0]   rx_word;
  logic [15:0]           cfg_addr_q, cfg_addr_d, cfg_data_q, cfg_data_d;
  logic                  cfg_valid_q, cfg_valid_d;

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    gap_d       = gap_q;
    shift_d     = shift_q;
    last_d      = last_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    fson_d      = fson_q;
    sdo_d       = sdo_q;
    sdo_t_d     = sdo_t_q;
    underrun_d  = 1'b0;
    start       = 1'b0;
    go_idle     = 1'b0;
    p_next      = p_q + 6'd1;
    xfer        = s_axis_tvalid & tready_q;

    if (fall_en) begin
      case (state_q)
        ST_IDLE: start = enable;
        ST_FRAME: begin
          if (p_q == P_LAST) begin
            if (FRAME_GAP == 0) begin
              start   = enable;
              go_idle = !enable;
            end else begin
              state_d = ST_GAP;
              gap_d   = '0;
              fson_d  = 1'b1;
              sdo_d   = 1'b0;
              sdo_t_d = 1'b1;
            end
          end else begin
            p_d    = p_next;
            fson_d = 1'b1;
            if (p_next == P_LAST) begin
              sdo_d   = 1'b0;
              sdo_t_d = 1'b1;
            end else begin
              // sample bits then status bits leave MSB first from one shifter
              sdo_d   = shift_q[SHIFT_BITS-1];
              sdo_t_d = 1'b0;
              shift_d = {shift_q[SHIFT_BITS-2:0], 1'b0};
            end
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            start   = enable;
            go_idle = !enable;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
        default: go_idle = 1'b1;
      endcase
    end

    if (go_idle) begin
      state_d = ST_IDLE;
      fson_d  = 1'b1;
      sdo_d   = 1'b0;
      sdo_t_d = 1'b1;
    end

    if (start) begin
      state_d = ST_FRAME;
      p_d     = '0;
      fson_d  = 1'b0;
      sdo_d   = 1'b0;
      sdo_t_d = 1'b0;
      if (hold_full_q) begin
        shift_d     = {hold_q, status};
        last_d      = hold_q;
        hold_full_d = 1'b0;
      end else begin
        shift_d    = {last_q, status};
        underrun_d = 1'b1;
      end
    end

    // a transfer seen alongside an empty-hold load lands here, after the load
    if (xfer) begin
      hold_d      = s_axis_tdata;
      hold_full_d = 1'b1;
    end
    tready_d = !hold_full_d;
  end

  always_comb begin
    rx_active_d = rx_active_q;
    rx_cnt_d    = rx_cnt_q;
    rx_sr_d     = rx_sr_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    cfg_valid_d = 1'b0;
    rx_word     = {rx_sr_q, adc_sdi};

    if (rise_en) begin
      if (!adc_fsin) begin
        rx_active_d = 1'b1;
        rx_cnt_d    = '0;
      end else if (rx_active_q) begin
        rx_sr_d  = rx_word[CFG_BITS-2:0];
        rx_cnt_d = rx_cnt_q + 6'd1;
        if (rx_cnt_q == RX_LAST) begin
          rx_active_d = 1'b0;
          cfg_addr_d  = rx_word[CFG_BITS-1 -: 16];
          cfg_data_d  = rx_word[15:0];
          cfg_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      gap_q       <= '0;
      shift_q     <= '0;
      last_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tready_q    <= 1'b0;
      fson_q      <= 1'b1;
      sdo_q       <= 1'b0;
      sdo_t_q     <= 1'b1;
      underrun_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_cnt_q    <= '0;
      rx_sr_q     <= '0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      cfg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      gap_q       <= gap_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tready_q    <= tready_d;
      fson_q      <= fson_d;
      sdo_q       <= sdo_d;
      sdo_t_q     <= sdo_t_d;
      underrun_q  <= underrun_d;
      rx_active_q <= rx_active_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_sr_q     <= rx_sr_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign adc_fson      = fson_q;
  assign adc_sdo       = sdo_q;
  assign adc_sdo_t     = sdo_t_q;
  assign underrun      = underrun_q;
  assign cfg_addr      = cfg_addr_q;
  assign cfg_data      = cfg_data_q;
  assign cfg_valid     = cfg_valid_q;

endmodule

// File: tb/tb_axis_ad7763_emu.sv
// tb/tb_axis_ad7763_emu.sv - bench for axis_ad7763_emu: frame decode per SCO period against a frame-rule model
module tb_axis_ad7763_emu;

  localparam int CLK_DIV = 2;
  localparam int GAP1    = 3;
  localparam int PER0    = 33 * 2 * CLK_DIV;
  localparam int PER1    = (33 + GAP1) * 2 * CLK_DIV;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable  = 1'b0;
  logic [6:0]  status  = '0;
  logic [23:0] tdata   = '0;
  logic        fsin    = 1'b1;
  logic        sdi     = 1'b0;
  logic        tvalid [2] = '{1'b0, 1'b0};
  logic        tready [2];
  logic        sco [2], fson [2], sdo [2], sdo_t [2], cfg_valid [2], underrun [2];
  logic [15:0] cfg_addr [2], cfg_data [2];

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  axis_ad7763_emu #(.CLK_DIV(CLK_DIV), .FRAME_GAP(0)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .status(status),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
    .adc_sco(sco[0]), .adc_fson(fson[0]), .adc_sdo(sdo[0]), .adc_sdo_t(sdo_t[0]),
    .adc_fsin(fsin), .adc_sdi(sdi),
    .cfg_addr(cfg_addr[0]), .cfg_data(cfg_data[0]), .cfg_valid(cfg_valid[0]),
    .underrun(underrun[0])
  );

  axis_ad7763_emu #(.CLK_DIV(CLK_DIV), .FRAME_GAP(GAP1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .status(status),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
    .adc_sco(sco[1]), .adc_fson(fson[1]), .adc_sdo(sdo[1]), .adc_sdo_t(sdo_t[1]),
    .adc_fsin(fsin), .adc_sdi(sdi),
    .cfg_addr(cfg_addr[1]), .cfg_data(cfg_data[1]), .cfg_valid(cfg_valid[1]),
    .underrun(underrun[1])
  );

  typedef struct {
    logic [32:0] f;
    logic [32:0] d;
    logic [32:0] t;
    int          start;
    int          gap;
  } frame_t;

  frame_t q0[$];
  frame_t q1[$];
  frame_t cur [2];
  int     pidx [2] = '{-1, -1};
  int     idle [2] = '{0, 0};
  logic   sco_prev [2] = '{1'b0, 1'b0};
  int     ur_cnt [2] = '{0, 0};
  int     cv_cnt [2] = '{0, 0};

  int tests = 0;
  int fails = 0;
  int fbase;

  // One record per SCO period, taken mid-period while SCO is high
  always @(negedge aclk) begin
    for (int k = 0; k < 2; k++) begin
      int     p;
      int     id;
      frame_t c;
      p  = pidx[k];
      id = idle[k];
      c  = cur[k];
      if (!aresetn) begin
        p  = -1;
        id = 0;
      end else if (sco[k] && !sco_prev[k]) begin
        if (p < 0) begin
          if (!fson[k]) begin
            p       = 0;
            c.start = cyc;
            c.gap   = id;
          end else if (sdo_t[k] && !sdo[k]) begin
            id = id + 1;
          end
        end
        if (p >= 0) begin
          c.f[p] = fson[k];
          c.d[p] = sdo[k];
          c.t[p] = sdo_t[k];
          p = p + 1;
          if (p == 33) begin
            if (k == 0) q0.push_back(c);
            else        q1.push_back(c);
            p  = -1;
            id = 0;
          end
        end
      end
      pidx[k]     <= p;
      idle[k]     <= id;
      cur[k]      <= c;
      sco_prev[k] <= sco[k];
      if (underrun[k])  ur_cnt[k] <= ur_cnt[k] + 1;
      if (cfg_valid[k]) cv_cnt[k] <= cv_cnt[k] + 1;
    end
  end

  function automatic void exp_frame(input logic [23:0] s, input logic [6:0] st,
                                    output logic [32:0] f, output logic [32:0] d,
                                    output logic [32:0] t);
    for (int p = 0; p < 33; p++) begin
      f[p] = (p != 0);
      t[p] = (p == 32);
      if (p >= 1 && p <= 24)       d[p] = s[24 - p];
      else if (p >= 25 && p <= 31) d[p] = st[31 - p];
      else                         d[p] = 1'b0;
    end
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic push(input int k, input logic [23:0] v);
    int n = 0;
    tdata     = v;
    tvalid[k] = 1'b1;
    while (!tready[k] && n < 1000) begin
      tick();
      n++;
    end
    tests++;
    if (tready[k] !== 1'b1) begin
      fails++;
      $display("FAIL push_dut%0d: tready=%b required 1 within 1000 cycles", k, tready[k]);
    end
    tick();
    tvalid[k] = 1'b0;
  endtask

  task automatic wait_frames(input int k, input int n);
    int t = 0;
    while (qsize(k) < n && t < 20000) begin
      tick();
      t++;
    end
    tests++;
    if (qsize(k) < n) begin
      fails++;
      $display("FAIL frame_wait_dut%0d: frames=%0d required %0d", k, qsize(k), n);
    end
  endtask

  task automatic sco_fall();
    logic prev;
    int   n = 0;
    prev = sco[0];
    forever begin
      tick();
      n++;
      if (prev === 1'b1 && sco[0] === 1'b0) break;
      if (n > 100) begin
        tests++;
        fails++;
        $display("FAIL sco_fall: no SCO falling edge within 100 cycles");
        break;
      end
      prev = sco[0];
    end
  endtask

  task automatic send_cfg(input logic [31:0] w, input int nbits);
    sco_fall();
    fsin = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sco_fall();
      fsin = 1'b1;
      sdi  = w[31 - i];
    end
    sco_fall();
    fsin = 1'b1;
    sdi  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    enable  = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({sco[k], fson[k], sdo[k], sdo_t[k], tready[k], cfg_valid[k], underrun[k]} !== 7'b0101000) begin
        fails++;
        $display("FAIL reset_outputs_dut%0d: sco,fson,sdo,sdo_t,tready,cfg_valid,underrun=%b required 0101000",
                 k, {sco[k], fson[k], sdo[k], sdo_t[k], tready[k], cfg_valid[k], underrun[k]});
      end
      tests++;
      if ({cfg_addr[k], cfg_data[k]} !== 32'h0) begin
        fails++;
        $display("FAIL reset_cfg_dut%0d: cfg=%h required 00000000", k, {cfg_addr[k], cfg_data[k]});
      end
    end
    aresetn = 1'b1;
    tick();
    tests++;
    if (tready[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_tready_after_release: tready=%b required 1", tready[0]);
    end
  endtask

  task automatic test_single_frame();
    logic [32:0] ef, ed, et;
    int          ub;
    status = 7'h55;
    fbase  = q0.size();
    ub     = ur_cnt[0];
    push(0, 24'hA5A5A5);
    enable = 1'b1;
    wait_frames(0, fbase + 1);
    exp_frame(24'hA5A5A5, 7'h55, ef, ed, et);
    tests++;
    if (q0[fbase].f !== ef || q0[fbase].d !== ed || q0[fbase].t !== et) begin
      fails++;
      $display("FAIL single_frame: fson=%h sdo=%h sdo_t=%h required %h %h %h",
               q0[fbase].f, q0[fbase].d, q0[fbase].t, ef, ed, et);
    end
    tests++;
    if (ur_cnt[0] - ub !== 0) begin
      fails++;
      $display("FAIL single_frame_underrun: pulses=%0d required 0", ur_cnt[0] - ub);
    end
  endtask

  task automatic test_underrun();
    logic [32:0] ef, ed, et;
    int          ub;
    ub = ur_cnt[0];
    wait_frames(0, fbase + 2);
    exp_frame(24'hA5A5A5, 7'h55, ef, ed, et);
    tests++;
    if (q0[fbase+1].f !== ef || q0[fbase+1].d !== ed || q0[fbase+1].t !== et) begin
      fails++;
      $display("FAIL underrun_repeat: fson=%h sdo=%h sdo_t=%h required %h %h %h",
               q0[fbase+1].f, q0[fbase+1].d, q0[fbase+1].t, ef, ed, et);
    end
    tests++;
    if (q0[fbase+1].start - q0[fbase].start !== PER0) begin
      fails++;
      $display("FAIL frame_period: cycles=%0d required %0d", q0[fbase+1].start - q0[fbase].start, PER0);
    end
    tests++;
    if (ur_cnt[0] - ub !== 1) begin
      fails++;
      $display("FAIL underrun_pulses: pulses=%0d required 1", ur_cnt[0] - ub);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] smp[8];
    logic [32:0] ef, ed, et;
    int          base, ub;
    enable = 1'b0;
    repeat (300) tick();
    status = 7'($urandom);
    smp[0] = 24'd1;
    smp[1] = 24'd2;
    smp[2] = 24'd3;
    for (int i = 3; i < 8; i++) smp[i] = 24'($urandom);
    base = q0.size();
    ub   = ur_cnt[0];
    push(0, smp[0]);
    enable = 1'b1;
    for (int i = 1; i < 8; i++) push(0, smp[i]);
    wait_frames(0, base + 8);
    for (int i = 0; i < 8; i++) begin
      exp_frame(smp[i], status, ef, ed, et);
      tests++;
      if (q0[base+i].f !== ef || q0[base+i].d !== ed || q0[base+i].t !== et) begin
        fails++;
        $display("FAIL b2b_frame%0d: fson=%h sdo=%h sdo_t=%h required %h %h %h",
                 i, q0[base+i].f, q0[base+i].d, q0[base+i].t, ef, ed, et);
      end
      if (i > 0) begin
        tests++;
        if (q0[base+i].start - q0[base+i-1].start !== PER0 || q0[base+i].gap !== 0) begin
          fails++;
          $display("FAIL b2b_spacing%0d: cycles=%0d idle=%0d required %0d 0",
                   i, q0[base+i].start - q0[base+i-1].start, q0[base+i].gap, PER0);
        end
      end
    end
    tests++;
    if (ur_cnt[0] - ub !== 0) begin
      fails++;
      $display("FAIL b2b_underrun: pulses=%0d required 0", ur_cnt[0] - ub);
    end
  endtask

  task automatic test_frame_gap();
    logic [23:0] a, b;
    logic [32:0] ef, ed, et;
    int          base, ub;
    enable = 1'b0;
    repeat (400) tick();
    status = 7'($urandom);
    a      = 24'($urandom);
    b      = 24'($urandom);
    base   = q1.size();
    ub     = ur_cnt[1];
    push(1, a);
    enable = 1'b1;
    push(1, b);
    wait_frames(1, base + 2);
    exp_frame(a, status, ef, ed, et);
    tests++;
    if (q1[base].f !== ef || q1[base].d !== ed || q1[base].t !== et) begin
      fails++;
      $display("FAIL gap_frame0: fson=%h sdo=%h sdo_t=%h required %h %h %h",
               q1[base].f, q1[base].d, q1[base].t, ef, ed, et);
    end
    exp_frame(b, status, ef, ed, et);
    tests++;
    if (q1[base+1].f !== ef || q1[base+1].d !== ed || q1[base+1].t !== et) begin
      fails++;
      $display("FAIL gap_frame1: fson=%h sdo=%h sdo_t=%h required %h %h %h",
               q1[base+1].f, q1[base+1].d, q1[base+1].t, ef, ed, et);
    end
    tests++;
    if (q1[base+1].start - q1[base].start !== PER1) begin
      fails++;
      $display("FAIL gap_period: cycles=%0d required %0d", q1[base+1].start - q1[base].start, PER1);
    end
    tests++;
    if (q1[base+1].gap !== GAP1) begin
      fails++;
      $display("FAIL gap_idle_periods: idle=%0d required %0d", q1[base+1].gap, GAP1);
    end
    tests++;
    if (ur_cnt[1] - ub !== 0) begin
      fails++;
      $display("FAIL gap_underrun: pulses=%0d required 0", ur_cnt[1] - ub);
    end
  endtask

  task automatic test_cfg_rx();
    logic [31:0] words[3];
    int          cb;
    words[0] = 32'h0001_1234;
    words[1] = $urandom;
    words[2] = $urandom;
    for (int i = 0; i < 2; i++) begin
      cb = cv_cnt[0];
      send_cfg(words[i], 32);
      tests++;
      if ({cfg_addr[0], cfg_data[0]} !== words[i] || cv_cnt[0] - cb !== 1) begin
        fails++;
        $display("FAIL cfg_word%0d: addr=%h data=%h pulses=%0d required %h %h 1",
                 i, cfg_addr[0], cfg_data[0], cv_cnt[0] - cb, words[i][31:16], words[i][15:0]);
      end
    end
    cb = cv_cnt[0];
    send_cfg($urandom, 10);
    send_cfg(words[2], 32);
    tests++;
    if ({cfg_addr[0], cfg_data[0]} !== words[2] || cv_cnt[0] - cb !== 1) begin
      fails++;
      $display("FAIL cfg_restart: addr=%h data=%h pulses=%0d required %h %h 1",
               cfg_addr[0], cfg_data[0], cv_cnt[0] - cb, words[2][31:16], words[2][15:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] x;
    logic [32:0] ef, ed, et;
    int          n = 0;
    int          base, ub;
    enable = 1'b1;
    while (pidx[0] != 13 && n < 2000) begin
      tick();
      n++;
    end
    tests++;
    if (pidx[0] != 13) begin
      fails++;
      $display("FAIL midreset_reach_p12: period index=%0d required 13", pidx[0]);
    end
    aresetn = 1'b0;
    #1;
    tests++;
    if ({sco[0], fson[0], sdo[0], sdo_t[0], tready[0], cfg_valid[0], underrun[0]} !== 7'b0101000) begin
      fails++;
      $display("FAIL midreset_outputs: sco,fson,sdo,sdo_t,tready,cfg_valid,underrun=%b required 0101000",
               {sco[0], fson[0], sdo[0], sdo_t[0], tready[0], cfg_valid[0], underrun[0]});
    end
    tests++;
    if ({cfg_addr[0], cfg_data[0]} !== 32'h0) begin
      fails++;
      $display("FAIL midreset_cfg: cfg=%h required 00000000", {cfg_addr[0], cfg_data[0]});
    end
    enable = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    repeat (2) tick();
    base   = q0.size();
    ub     = ur_cnt[0];
    x      = 24'($urandom);
    status = 7'($urandom);
    push(0, x);
    enable = 1'b1;
    wait_frames(0, base + 1);
    exp_frame(x, status, ef, ed, et);
    tests++;
    if (q0[base].f !== ef || q0[base].d !== ed || q0[base].t !== et) begin
      fails++;
      $display("FAIL midreset_first_frame: fson=%h sdo=%h sdo_t=%h required %h %h %h",
               q0[base].f, q0[base].d, q0[base].t, ef, ed, et);
    end
    tests++;
    if (ur_cnt[0] - ub !== 0) begin
      fails++;
      $display("FAIL midreset_underrun: pulses=%0d required 0", ur_cnt[0] - ub);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_underrun();
    test_back_to_back();
    test_frame_gap();
    test_cfg_rx();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
